// File: rtl/lane_distributor_param.sv
// Parametrised tx lane distributor: splits a wide word into per-lane units, inserts
// periodic alignment syncs and comp stall slots. Optional forced sync: DIST_SYNC_TIMEOUT_EN.

module lane_distributor_lane #(
  parameter int UNITW = 66
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [UNITW-1:0] data_i,
  input  logic             en_i,
  input  logic             sync_i,
  output logic [UNITW-1:0] data_o,
  output logic             en_o,
  output logic             sync_o
);
  logic [UNITW-1:0] data_q;
  logic             en_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      en_q   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      en_q   <= ce_i & en_i;
      sync_q <= ce_i & sync_i;
      if (ce_i) data_q <= data_i;
    end
  end

  assign data_o = data_q;
  assign en_o   = en_q;
  assign sync_o = sync_q;
endmodule

module lane_distributor_param #(
  parameter int LANES         = 4,
  parameter int UNITW         = 66,
  parameter int SYNC_PERIOD   = 1024,
  parameter int COMP_INTERVAL = 384,
  parameter int SYNC_TIMEOUT  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_enable,
  input  logic [LANES*UNITW-1:0] in_txdata,
  input  logic                   in_txdata_en,
  input  logic                   in_empty,
  input  logic [LANES-1:0]       in_lane_mask,
  input  logic [LANES-1:0]       in_lane_idle,
  output logic                   out_ready,
  output logic                   out_syncing_pre,
  output logic [LANES*UNITW-1:0] out_txdata,
  output logic [LANES-1:0]       out_txdata_en,
  output logic [LANES-1:0]       out_txsync,
  output logic [LANES-1:0]       out_active_mask,
  output logic                   out_sync_timeout
);
  localparam int CW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;

  typedef enum logic [1:0] {NORMAL, WAIT_CLEAN, WAIT_IDLE} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [LANES-1:0]             mask_q, mask_d;
  logic [LANES-1:0]             en_d, sync_d, fwd_en;
  logic                         allidle, stall, force_sync;
  logic [LANES-1:0][UNITW-1:0]  txd_in, txd_out;

  assign txd_in     = in_txdata;
  assign out_txdata = txd_out;
  assign allidle    = &(in_lane_idle | ~mask_q);
  // COMP_INTERVAL >= SYNC_PERIOD never hits a nonzero multiple, so slots vanish
  assign stall      = (cnt_q != '0) && ((int'(cnt_q) % COMP_INTERVAL) == 0);
  assign fwd_en     = {LANES{in_txdata_en}} & mask_q;
  assign out_active_mask = mask_q;

`ifdef DIST_SYNC_TIMEOUT_EN
  localparam int TW = $clog2(SYNC_TIMEOUT + 1) + 1;
  logic [TW-1:0] wait_q, wait_d;
  logic          to_q;

  assign force_sync = (state_q != NORMAL) && (int'(wait_q) >= SYNC_TIMEOUT - 1);

  always_comb begin
    wait_d = wait_q;
    if (in_enable) wait_d = (state_q == NORMAL) ? '0 : wait_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      if (in_enable && force_sync) to_q <= 1'b1;
    end
  end

  assign out_sync_timeout = to_q;
`else
  assign force_sync       = 1'b0;
  assign out_sync_timeout = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mask_d          = mask_q;
    en_d            = '0;
    sync_d          = '0;
    out_ready       = 1'b0;
    out_syncing_pre = 1'b0;
    if (in_enable) begin
      if (force_sync) begin
        sync_d  = mask_q;
        en_d    = mask_q;
        state_d = NORMAL;
        cnt_d   = CW'(1);
      end else begin
        case (state_q)
          NORMAL: begin
            cnt_d = cnt_q + CW'(1);
            if (!stall) begin
              out_ready = allidle;
              en_d      = fwd_en;
            end
            // Mask swaps only here so lanes change membership at a sync boundary
            if (cnt_q == '0) begin
              if (|in_lane_mask) mask_d = in_lane_mask;
              if (in_empty) state_d = WAIT_IDLE;
              else begin
                state_d         = WAIT_CLEAN;
                out_syncing_pre = 1'b1;
              end
            end
          end
          WAIT_CLEAN: begin
            if (in_empty) state_d = WAIT_IDLE;
            else begin
              out_syncing_pre = 1'b1;
              out_ready       = allidle;
              en_d            = fwd_en;
            end
          end
          WAIT_IDLE: begin
            if (allidle) begin
              sync_d  = mask_q;
              en_d    = mask_q;
              state_d = NORMAL;
              cnt_d   = CW'(1);
            end
          end
          default: state_d = NORMAL;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_distributor_lane #(.UNITW(UNITW)) u_lane (
      .clk_i  (clk),
      .rst_i  (reset),
      .ce_i   (in_enable),
      .data_i (txd_in[i]),
      .en_i   (en_d[i]),
      .sync_i (sync_d[i]),
      .data_o (txd_out[i]),
      .en_o   (out_txdata_en[i]),
      .sync_o (out_txsync[i])
    );
  end
endmodule

// File: tb/tb_lane_distributor_param.sv
// Randomised bench for lane_distributor_param against a cycle-level behavioural model.
module tb_lane_distributor_param;
  localparam int LANES = 4, UNITW = 66, SP = 1024, CI = 384, DW = LANES * UNITW;

  logic clk = 1'b0;
  logic reset, in_enable, in_txdata_en, in_empty;
  logic [DW-1:0]    in_txdata;
  logic [LANES-1:0] in_lane_mask, in_lane_idle;
  logic             out_ready, out_syncing_pre, out_sync_timeout;
  logic [DW-1:0]    out_txdata;
  logic [LANES-1:0] out_txdata_en, out_txsync, out_active_mask;

  int checks = 0, errors = 0;

  // model: mode 0 run, 1 draining swizzler, 2 waiting for lanes idle
  int               m_mode, m_cnt;
  logic [LANES-1:0] m_mask, e_en, e_sync;
  logic [DW-1:0]    e_data;
  logic             e_ready, e_pre, obs_ready, obs_pre;

  lane_distributor_param #(.LANES(LANES), .UNITW(UNITW), .SYNC_PERIOD(SP),
                           .COMP_INTERVAL(CI), .SYNC_TIMEOUT(256)) dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_txdata(in_txdata),
    .in_txdata_en(in_txdata_en), .in_empty(in_empty), .in_lane_mask(in_lane_mask),
    .in_lane_idle(in_lane_idle), .out_ready(out_ready), .out_syncing_pre(out_syncing_pre),
    .out_txdata(out_txdata), .out_txdata_en(out_txdata_en), .out_txsync(out_txsync),
    .out_active_mask(out_active_mask), .out_sync_timeout(out_sync_timeout));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW; k++) d[k] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // One clock: capture combinational outputs mid-cycle, advance the model, settle after the edge.
  task automatic step();
    logic allid, stall;
    logic [LANES-1:0] nen, nsync;
    @(negedge clk);
    obs_ready = out_ready;
    obs_pre   = out_syncing_pre;
    allid   = ((in_lane_idle | ~m_mask) == '1);
    e_ready = 1'b0; e_pre = 1'b0; nen = '0; nsync = '0;
    if (in_enable) begin
      e_data = in_txdata;
      if (m_mode == 0) begin
        stall   = (m_cnt != 0) && (m_cnt % CI == 0);
        e_ready = allid && !stall;
        nen     = (stall || !in_txdata_en) ? '0 : m_mask;
        if (m_cnt == 0) begin
          e_pre  = !in_empty;
          m_mode = in_empty ? 2 : 1;
          if (in_lane_mask != '0) m_mask = in_lane_mask;
        end
        m_cnt = (m_cnt + 1) % SP;
      end else if (m_mode == 1) begin
        if (in_empty) m_mode = 2;
        else begin
          e_pre = 1'b1; e_ready = allid; nen = in_txdata_en ? m_mask : '0;
        end
      end else if (allid) begin
        nsync = m_mask; nen = m_mask; m_mode = 0; m_cnt = 1;
      end
    end
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_mask = '1; e_data = '0; nen = '0; nsync = '0;
    end
    e_en = nen; e_sync = nsync;
    @(posedge clk); #1;
  endtask

  task automatic run_to_boundary();
    int n = 0;
    while (!(m_mode == 0 && m_cnt == 0) && n < 1200) begin
      in_txdata = rnd_data();
      step();
      n++;
    end
    checks++;
    if (n >= 1200) begin errors++; $display("FAIL boundary_timeout got %0d cycles required <1200", n); end
  endtask

  task automatic test_reset();
    reset = 1; in_enable = 1; in_empty = 1; in_lane_idle = '1; in_lane_mask = '1;
    in_txdata_en = 0; in_txdata = '0;
    step(); step();
    checks++;
    if ({out_txdata_en, out_txsync, out_active_mask, out_sync_timeout} !== {4'h0, 4'h0, 4'hF, 1'b0}
        || out_txdata !== '0) begin
      errors++; $display("FAIL reset_state got en=%h sync=%h mask=%h to=%b", out_txdata_en,
                         out_txsync, out_active_mask, out_sync_timeout);
    end
    reset = 0;
    step(); step();
    checks++;
    if (out_txsync !== 4'b1111 || out_txdata_en !== 4'b1111) begin
      errors++; $display("FAIL first_sync got sync=%h en=%h required 1111/1111", out_txsync, out_txdata_en);
    end
    for (int i = 0; i < 6; i++) begin
      in_txdata_en = 1; in_txdata = rnd_data();
      step();
      checks++;
      if (obs_ready !== 1'b1 || out_txdata !== in_txdata || out_txdata_en !== 4'hF) begin
        errors++; $display("FAIL pass_through got rdy=%b en=%h data_ok=%b", obs_ready, out_txdata_en,
                           out_txdata === in_txdata);
      end
    end
  endtask

  task automatic test_period();
    int s1 = -1, s2 = -1, cb, mb;
    in_txdata_en = 1; in_empty = 1; in_lane_idle = '1;
    for (int i = 0; i < 2400 && s2 < 0; i++) begin
      cb = m_cnt; mb = m_mode;
      in_txdata = rnd_data();
      step();
      checks++;
      if ({obs_ready, obs_pre, out_txdata_en, out_txsync, out_active_mask} !==
          {e_ready, e_pre, e_en, e_sync, m_mask} || out_txdata !== e_data) begin
        errors++; $display("FAIL period_model i=%0d got r%b p%b en%h s%h m%h exp r%b p%b en%h s%h m%h",
          i, obs_ready, obs_pre, out_txdata_en, out_txsync, out_active_mask, e_ready, e_pre, e_en, e_sync, m_mask);
      end
      if (mb == 0 && (cb == 384 || cb == 768)) begin
        checks++;
        if (obs_ready !== 1'b0 || out_txdata_en !== 4'h0) begin
          errors++; $display("FAIL stall_slot cnt=%0d got rdy=%b en=%h required 0/0", cb, obs_ready, out_txdata_en);
        end
      end
      if (out_txsync !== 4'h0) begin
        if (s1 < 0) s1 = i; else s2 = i;
      end
    end
    checks++;
    if (s1 < 0 || s2 - s1 != 1025) begin
      errors++; $display("FAIL sync_spacing got %0d required 1025", s2 - s1);
    end
  endtask

  task automatic test_drain();
    int pre_n = 0;
    in_empty = 1; in_lane_idle = '1; in_txdata_en = 1;
    run_to_boundary();
    in_empty = 0;
    for (int i = 0; i < 6; i++) begin
      in_txdata = rnd_data();
      step();
      pre_n += obs_pre ? 1 : 0;
      checks++;
      if (out_txdata_en !== 4'hF || out_txdata !== in_txdata || out_txsync !== 4'h0) begin
        errors++; $display("FAIL drain_forward got en=%h sync=%h required F/0", out_txdata_en, out_txsync);
      end
    end
    checks++;
    if (pre_n != 6) begin errors++; $display("FAIL syncing_pre_len got %0d required 6", pre_n); end
    in_empty = 1; in_lane_idle = 4'b1110;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs_ready !== 1'b0 || obs_pre !== 1'b0 || out_txsync !== 4'h0 || out_txdata_en !== 4'h0) begin
        errors++; $display("FAIL drain_wait got rdy=%b pre=%b sync=%h en=%h required 0/0/0/0",
                           obs_ready, obs_pre, out_txsync, out_txdata_en);
      end
    end
    in_lane_idle = '1;
    step();
    checks++;
    if (out_txsync !== 4'hF || out_txsync !== e_sync) begin
      errors++; $display("FAIL drain_sync got %h required F", out_txsync);
    end
  endtask

  task automatic test_mask();
    in_lane_mask = 4'b0011; in_lane_idle = 4'b0111; in_empty = 1; in_txdata_en = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_active_mask !== 4'hF) begin
        errors++; $display("FAIL mask_early got %h required F", out_active_mask);
      end
    end
    run_to_boundary();
    step();
    step();
    checks++;
    if (out_txsync !== 4'b0011 || out_active_mask !== 4'b0011) begin
      errors++; $display("FAIL mask_sync got sync=%h mask=%h required 3/3", out_txsync, out_active_mask);
    end
    for (int i = 0; i < 20; i++) begin
      in_txdata = rnd_data();
      step();
      checks++;
      if ((out_txdata_en & 4'b1100) !== 4'h0 || out_txdata !== in_txdata || out_txdata_en !== e_en) begin
        errors++; $display("FAIL mask_lanes got en=%h required %h", out_txdata_en, e_en);
      end
    end
    in_lane_mask = 4'b0000;
    run_to_boundary();
    step(); step();
    checks++;
    if (out_active_mask !== 4'b0011 || out_txsync !== 4'b0011) begin
      errors++; $display("FAIL mask_zero_keep got mask=%h sync=%h required 3/3", out_active_mask, out_txsync);
    end
  endtask

  task automatic test_enable_reset();
    in_empty = 1; in_lane_idle = 4'b1110; in_lane_mask = 4'b0011;
    run_to_boundary();
    step();
    for (int i = 0; i < 8; i++) begin
      in_enable = 1'(i % 2);
      step();
      checks++;
      if (obs_ready !== 1'b0 || obs_pre !== 1'b0 || out_txsync !== 4'h0 || out_txdata_en !== 4'h0
          || out_txdata !== e_data) begin
        errors++; $display("FAIL wait_enable got rdy=%b pre=%b sync=%h en=%h", obs_ready, obs_pre,
                           out_txsync, out_txdata_en);
      end
    end
    reset = 1; in_enable = 0;
    step();
    checks++;
    if (out_txdata_en !== 4'h0 || out_txsync !== 4'h0 || out_txdata !== '0 || out_active_mask !== 4'hF) begin
      errors++; $display("FAIL mid_reset got en=%h sync=%h mask=%h", out_txdata_en, out_txsync, out_active_mask);
    end
    reset = 0; in_enable = 1; in_lane_idle = '1; in_lane_mask = '1;
    step(); step();
    checks++;
    if (out_txsync !== 4'hF) begin
      errors++; $display("FAIL post_reset_sync got %h required F", out_txsync);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 999) == 0);
      in_enable    = ($urandom_range(0, 7) != 0);
      in_txdata_en = 1'($urandom_range(0, 1));
      in_empty     = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < LANES; l++) in_lane_idle[l] = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) in_lane_mask = 4'($urandom_range(0, 15));
      in_txdata = rnd_data();
      step();
      checks++;
      if ({obs_ready, obs_pre, out_txdata_en, out_txsync, out_active_mask, out_sync_timeout} !==
          {e_ready, e_pre, e_en, e_sync, m_mask, 1'b0} || out_txdata !== e_data) begin
        errors++; $display("FAIL random_model i=%0d got r%b p%b en%h s%h m%h exp r%b p%b en%h s%h m%h",
          i, obs_ready, obs_pre, out_txdata_en, out_txsync, out_active_mask, e_ready, e_pre, e_en, e_sync, m_mask);
      end
    end
  endtask

  initial begin
    m_mode = 0; m_cnt = 0; m_mask = '1; e_data = '0; e_en = '0; e_sync = '0;
    reset = 1; in_enable = 1; in_txdata_en = 0; in_empty = 1; in_txdata = '0;
    in_lane_mask = '1; in_lane_idle = '1;
    @(posedge clk); #1;
    test_reset();
    test_period();
    test_drain();
    test_mask();
    test_enable_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
